// File: rtl/afe_pot_sched.sv
// afe_pot_sched: coalesces AFE pot requests per target and round-robins them onto the shared SPI master,
// alternating with EEPROM grants. Optional macro AFE_REFRESH_EN adds a periodic re-send of written targets.
`timescale 1ns/1ps
module afe_pot_sched #(
  parameter int GAP_CYC     = 4,
  parameter int REFRESH_CYC = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gain_wrt,
  input  logic [1:0]  gain_ch,
  input  logic [2:0]  gain_code,
  input  logic        trig_wrt,
  input  logic [7:0]  trig_lvl,
  output logic        req_ack,
  output logic        req_err,
  input  logic        eep_req,
  output logic        eep_gnt,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  output logic [3:0]  ss_en,
  output logic [3:0]  pend,
  output logic        idle
);

  if (GAP_CYC < 1 || GAP_CYC > 255 || REFRESH_CYC < 2) begin : g_param_check
    $error("afe_pot_sched: GAP_CYC must be 1..255 and REFRESH_CYC at least 2");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_GAP, ST_EEP} state_t;

  function automatic logic [7:0] gain_byte(input logic [2:0] code);
    case (code)
      3'd0:    gain_byte = 8'h02;
      3'd1:    gain_byte = 8'h05;
      3'd2:    gain_byte = 8'h09;
      3'd3:    gain_byte = 8'h14;
      3'd4:    gain_byte = 8'h28;
      3'd5:    gain_byte = 8'h46;
      3'd6:    gain_byte = 8'h6B;
      default: gain_byte = 8'hDD;
    endcase
  endfunction

  // First pending target after the last-served one; later candidates are overwritten by earlier ones.
  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + k[1:0];
      if (p[idx]) rr_pick = idx;
    end
  endfunction

  state_t          state;
  logic [3:0][7:0] shadow;
  logic [1:0]      last;
  logic [1:0]      pick;
  logic            last_pot;
  logic [7:0]      gap_cnt;
  logic            gain_ok;
  logic            trig_ok;
  logic            eep_take;
  logic [3:0]      req_set;
  logic [3:0]      pick_oh;
  logic [3:0]      pend_clr;
  logic [3:0]      refresh_set;

  assign gain_ok  = gain_wrt && (gain_ch != 2'b11);
  assign trig_ok  = trig_wrt && (trig_lvl >= 8'd46) && (trig_lvl <= 8'd201);
  assign pick     = rr_pick(pend, last);
  assign pick_oh  = 4'b0001 << pick;
  assign eep_take = eep_req && ((pend == 4'b0000) || last_pot);
  assign pend_clr = (state == ST_IDLE && !eep_take) ? (pick_oh & pend) : 4'b0000;
  assign idle     = (state == ST_IDLE) && (pend == 4'b0000) && !eep_gnt;

  always_comb begin
    req_set = 4'b0000;
    if (gain_ok) req_set[gain_ch] = 1'b1;
    if (trig_ok) req_set[3] = 1'b1;
  end

`ifdef AFE_REFRESH_EN
  localparam int RW = $clog2(REFRESH_CYC);
  logic [3:0]    written;
  logic [RW-1:0] ref_cnt;
  logic          ref_hit;

  assign ref_hit     = (ref_cnt == RW'(REFRESH_CYC - 1));
  assign refresh_set = ((|written) && ref_hit) ? written : 4'b0000;

  // Counter stays parked until the first accepted write; shadows are never touched here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written <= 4'b0000;
      ref_cnt <= '0;
    end else begin
      written <= written | req_set;
      if (|written) ref_cnt <= ref_hit ? '0 : ref_cnt + RW'(1);
    end
  end
`else
  assign refresh_set = 4'b0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pend     <= 4'b0000;
      shadow   <= '0;
      last     <= 2'd3;
      last_pot <= 1'b0;
      gap_cnt  <= 8'd0;
      req_ack  <= 1'b0;
      req_err  <= 1'b0;
      eep_gnt  <= 1'b0;
      spi_wrt  <= 1'b0;
      spi_cmd  <= 16'h0000;
      ss_en    <= 4'b0000;
    end else begin
      req_ack <= gain_ok | trig_ok;
      req_err <= (gain_wrt & ~gain_ok) | (trig_wrt & ~trig_ok);
      if (gain_ok) shadow[gain_ch] <= gain_byte(gain_code);
      if (trig_ok) shadow[3] <= trig_lvl;
      // New requests win over the in-flight clear so a re-posted target is sent again.
      pend    <= (pend & ~pend_clr) | req_set | refresh_set;
      spi_wrt <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (eep_take) begin
            eep_gnt  <= 1'b1;
            last_pot <= 1'b0;
            state    <= ST_EEP;
          end else if (pend != 4'b0000) begin
            spi_cmd  <= {8'h13, shadow[pick]};
            ss_en    <= pick_oh;
            last     <= pick;
            last_pot <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          spi_wrt <= 1'b1;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_done) begin
            ss_en   <= 4'b0000;
            gap_cnt <= 8'(GAP_CYC - 1);
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        ST_EEP: begin
          if (!eep_req) begin
            eep_gnt <= 1'b0;
            gap_cnt <= 8'(GAP_CYC - 1);
            state   <= ST_GAP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afe_pot_sched.sv
// tb_afe_pot_sched: directed table/sequence tests plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_afe_pot_sched;
  localparam int GAP = 4;
  localparam int NR  = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gain_wrt = 1'b0;
  logic [1:0]  gain_ch = 2'd0;
  logic [2:0]  gain_code = 3'd0;
  logic        trig_wrt = 1'b0;
  logic [7:0]  trig_lvl = 8'd0;
  logic        req_ack, req_err;
  logic        eep_req = 1'b0;
  logic        eep_gnt;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done = 1'b0;
  logic [3:0]  ss_en, pend;
  logic        idle;

  always #5 clk = ~clk;

  afe_pot_sched #(.GAP_CYC(GAP), .REFRESH_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .gain_wrt(gain_wrt), .gain_ch(gain_ch), .gain_code(gain_code),
    .trig_wrt(trig_wrt), .trig_lvl(trig_lvl), .req_ack(req_ack), .req_err(req_err),
    .eep_req(eep_req), .eep_gnt(eep_gnt), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
    .spi_done(spi_done), .ss_en(ss_en), .pend(pend), .idle(idle)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       gw;
    logic [1:0] gch;
    logic [2:0] gcode;
    logic       tw;
    logic [7:0] tl;
    logic       ack;
    logic       err;
    logic [3:0] pnd;
  } vec_t;

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  ss;
  } drain_t;

  vec_t       vt [11];
  drain_t     dt [4];
  logic [7:0] gtab [8];
  byte        seq [$];
  string      exp_s = "EPEPEP";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clr_in();
    gain_wrt = 1'b0; trig_wrt = 1'b0; spi_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr_in(); eep_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_wrt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_wrt) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      spi_done = spi_wrt;
      if (idle) begin ok = 1'b1; spi_done = 1'b0; return; end
    end
    spi_done = 1'b0;
  endtask

  task automatic start_wait();
    bit ok;
    gain_wrt = 1'b1; gain_ch = 2'd0; gain_code = 3'd0;
    @(negedge clk);
    gain_wrt = 1'b0;
    wait_wrt(ok);
    chk("start_wrt_timeout", 32'(ok), 32'd1);
  endtask

  function automatic int rr(input logic [3:0] p, input int l);
    for (int k = 1; k <= 4; k++) if (p[(l + k) % 4]) return (l + k) % 4;
    return 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int t, dly, hold, rel_cyc, ecnt, ehold;
    logic [3:0] m_pend;
    logic [7:0] m_sh [4];
    int m_last;
    logic m_lastpot, g_ok, t_ok, prev_gnt;
    logic [3:0] prev_ss;

    gtab = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};
    vt[0]  = '{1'b1, 2'd3, 3'd5, 1'b0, 8'd0,   1'b0, 1'b1, 4'b0000};
    vt[1]  = '{1'b0, 2'd0, 3'd0, 1'b1, 8'd45,  1'b0, 1'b1, 4'b0000};
    vt[2]  = '{1'b0, 2'd0, 3'd0, 1'b1, 8'd202, 1'b0, 1'b1, 4'b0000};
    vt[3]  = '{1'b0, 2'd0, 3'd0, 1'b1, 8'd46,  1'b1, 1'b0, 4'b1000};
    vt[4]  = '{1'b0, 2'd0, 3'd0, 1'b1, 8'd201, 1'b1, 1'b0, 4'b1000};
    vt[5]  = '{1'b1, 2'd1, 3'd4, 1'b0, 8'd0,   1'b1, 1'b0, 4'b1010};
    vt[6]  = '{1'b1, 2'd3, 3'd0, 1'b1, 8'h80,  1'b1, 1'b1, 4'b1010};
    vt[7]  = '{1'b1, 2'd2, 3'd7, 1'b1, 8'd30,  1'b1, 1'b1, 4'b1110};
    vt[8]  = '{1'b1, 2'd0, 3'd1, 1'b0, 8'd0,   1'b1, 1'b0, 4'b1111};
    vt[9]  = '{1'b1, 2'd0, 3'd5, 1'b0, 8'd0,   1'b1, 1'b0, 4'b1111};
    vt[10] = '{1'b0, 2'd0, 3'd0, 1'b0, 8'd0,   1'b0, 1'b0, 4'b1111};
    dt[0] = '{16'h1328, 4'b0010};
    dt[1] = '{16'h13DD, 4'b0100};
    dt[2] = '{16'h1380, 4'b1000};
    dt[3] = '{16'h1346, 4'b0001};

    // Reset values and single-request latency
    do_reset();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ss_en", 32'(ss_en), 32'd0);
    chk("rst_spi_wrt", 32'(spi_wrt), 32'd0);
    chk("rst_eep_gnt", 32'(eep_gnt), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    chk("rst_ack_err", 32'({req_ack, req_err}), 32'd0);
    chk("rst_spi_cmd", 32'(spi_cmd), 32'd0);
    gain_wrt = 1'b1; gain_ch = 2'd0; gain_code = 3'd0;
    @(negedge clk); gain_wrt = 1'b0;
    chk("lat_ack", 32'(req_ack), 32'd1);
    chk("lat_pend", 32'(pend), 32'b0001);
    @(negedge clk);
    chk("lat_ss_en", 32'(ss_en), 32'b0001);
    chk("lat_wrt_early", 32'(spi_wrt), 32'd0);
    @(negedge clk);
    chk("lat_wrt", 32'(spi_wrt), 32'd1);
    chk("lat_cmd", 32'(spi_cmd), 32'h1302);
    @(negedge clk);
    chk("lat_wrt_pulse", 32'(spi_wrt), 32'd0);
    chk("wait_ss_hold", 32'(ss_en), 32'b0001);
    spi_done = 1'b1;
    @(negedge clk); spi_done = 1'b0;
    chk("done_ss_drop", 32'(ss_en), 32'd0);
    chk("gap_idle0", 32'(idle), 32'd0);
    for (int i = 1; i < GAP; i++) begin
      @(negedge clk);
      chk($sformatf("gap_idle%0d", i), 32'(idle), 32'd0);
    end
    @(negedge clk);
    chk("gap_end_idle", 32'(idle), 32'd1);

    // Acceptance table applied while CH1 transaction is held in WAIT
    start_wait();
    for (int i = 0; i < 11; i++) begin
      gain_wrt = vt[i].gw; gain_ch = vt[i].gch; gain_code = vt[i].gcode;
      trig_wrt = vt[i].tw; trig_lvl = vt[i].tl;
      @(negedge clk);
      gain_wrt = 1'b0; trig_wrt = 1'b0;
      chk($sformatf("vec%0d_ack", i), 32'(req_ack), 32'(vt[i].ack));
      chk($sformatf("vec%0d_err", i), 32'(req_err), 32'(vt[i].err));
      chk($sformatf("vec%0d_pend", i), 32'(pend), 32'(vt[i].pnd));
      chk($sformatf("vec%0d_nospi", i), 32'({spi_wrt, ss_en}), 32'b00001);
    end
    spi_done = 1'b1; @(negedge clk); spi_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_wrt(ok);
      chk($sformatf("drain%0d_timeout", i), 32'(ok), 32'd1);
      chk($sformatf("drain%0d_cmd", i), 32'(spi_cmd), 32'(dt[i].cmd));
      chk($sformatf("drain%0d_ss", i), 32'(ss_en), 32'(dt[i].ss));
      spi_done = 1'b1; @(negedge clk); spi_done = 1'b0;
    end
    wait_idle(ok);
    chk("drain_idle", 32'(ok), 32'd1);
    chk("drain_pend", 32'(pend), 32'd0);

    // EEPROM / pot interleave with three pots pending
    start_wait();
    gain_wrt = 1'b1; gain_ch = 2'd1; gain_code = 3'd2; @(negedge clk);
    gain_ch = 2'd2; gain_code = 3'd3; @(negedge clk);
    gain_wrt = 1'b0; trig_wrt = 1'b1; trig_lvl = 8'd100; @(negedge clk);
    trig_wrt = 1'b0; eep_req = 1'b1; spi_done = 1'b1;
    prev_ss = ss_en; prev_gnt = 1'b0; ecnt = 0; ehold = 0;
    for (int i = 0; i < 300 && seq.size() < 6; i++) begin
      @(negedge clk);
      if (ss_en != 4'b0 && prev_ss == 4'b0) seq.push_back(8'h50);
      if (eep_gnt && !prev_gnt) begin seq.push_back(8'h45); ecnt++; ehold = 0; end
      if (eep_gnt) begin
        chk("eep_ss_zero", 32'(ss_en), 32'd0);
        ehold++;
        if (ehold >= 3) eep_req = 1'b0;
      end else if (!eep_req && ecnt < 3) eep_req = 1'b1;
      spi_done = spi_wrt;
      prev_ss = ss_en; prev_gnt = eep_gnt;
    end
    eep_req = 1'b0;
    chk("eep_seq_len", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("eep_seq%0d", i), 32'(seq.size() > i ? seq[i] : 8'h00), 32'(exp_s[i]));
    wait_idle(ok);
    chk("eep_end_idle", 32'(ok), 32'd1);

    // Asynchronous reset during WAIT
    start_wait();
    gain_wrt = 1'b1; gain_ch = 2'd1; gain_code = 3'd1;
    @(negedge clk); gain_wrt = 1'b0;
    chk("arst_pre_pend", 32'(pend), 32'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ss_en", 32'(ss_en), 32'd0);
    chk("arst_pend", 32'(pend), 32'd0);
    chk("arst_wrt_gnt", 32'({spi_wrt, eep_gnt}), 32'd0);
    @(negedge clk); rst_n = 1'b1; spi_done = 1'b1;
    @(negedge clk); spi_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_stale%0d", i), 32'({spi_wrt, ss_en, idle}), 32'd1);
      @(negedge clk);
    end

    // Randomized traffic against the transaction-level model
    do_reset();
    m_pend = 4'b0; m_sh = '{8'h0, 8'h0, 8'h0, 8'h0}; m_last = 3; m_lastpot = 1'b0;
    prev_ss = 4'b0; prev_gnt = 1'b0; rel_cyc = -100; dly = -1; hold = 0;
    for (int cyc = 0; cyc < NR + 400; cyc++) begin
      @(negedge clk);
      if (ss_en != 4'b0 && prev_ss == 4'b0) begin
        t = rr(m_pend, m_last);
        chk("rnd_pick_had_pend", 32'(m_pend != 4'b0), 32'd1);
        chk("rnd_rr_ss_en", 32'(ss_en), 32'(4'b0001 << t));
        chk("rnd_rr_cmd", 32'(spi_cmd), 32'({8'h13, m_sh[t]}));
        chk("rnd_arb_pot", 32'(eep_req && (m_pend == 4'b0 || m_lastpot)), 32'd0);
        chk("rnd_gap_pot", 32'(cyc - rel_cyc > GAP), 32'd1);
        m_pend[t] = 1'b0; m_last = t; m_lastpot = 1'b1;
      end
      if (eep_gnt && !prev_gnt) begin
        chk("rnd_arb_eep", 32'(m_pend == 4'b0 || m_lastpot), 32'd1);
        chk("rnd_gap_eep", 32'(cyc - rel_cyc > GAP), 32'd1);
        m_lastpot = 1'b0;
        hold = $urandom_range(0, 4);
      end
      if ((ss_en == 4'b0 && prev_ss != 4'b0) || (!eep_gnt && prev_gnt)) rel_cyc = cyc;
      if (eep_gnt) chk("rnd_eep_ss", 32'(ss_en), 32'd0);
      g_ok = gain_wrt && gain_ch != 2'd3;
      t_ok = trig_wrt && trig_lvl >= 8'd46 && trig_lvl <= 8'd201;
      chk("rnd_ack", 32'(req_ack), 32'(g_ok || t_ok));
      chk("rnd_err", 32'(req_err), 32'((gain_wrt && !g_ok) || (trig_wrt && !t_ok)));
      if (g_ok) begin m_pend[gain_ch] = 1'b1; m_sh[gain_ch] = gtab[gain_code]; end
      if (t_ok) begin m_pend[3] = 1'b1; m_sh[3] = trig_lvl; end
      chk("rnd_pend", 32'(pend), 32'(m_pend));
      prev_ss = ss_en; prev_gnt = eep_gnt;

      if (cyc < NR) begin
        gain_wrt = ($urandom_range(0, 5) == 0);
        gain_ch = 2'($urandom_range(0, 3));
        gain_code = 3'($urandom_range(0, 7));
        trig_wrt = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 4))
          0: trig_lvl = 8'd45;
          1: trig_lvl = 8'd46;
          2: trig_lvl = 8'd201;
          3: trig_lvl = 8'd202;
          default: trig_lvl = 8'($urandom_range(0, 255));
        endcase
      end else begin
        gain_wrt = 1'b0; trig_wrt = 1'b0;
      end
      spi_done = 1'b0;
      if (spi_wrt) dly = $urandom_range(0, 3);
      if (dly == 0) begin spi_done = 1'b1; dly = -1; end
      else if (dly > 0) dly--;
      else if (ss_en == 4'b0 && $urandom_range(0, 30) == 0) spi_done = 1'b1;
      if (cyc >= NR) eep_req = 1'b0;
      else if (!eep_req) eep_req = ($urandom_range(0, 15) == 0);
      else if (eep_gnt) begin
        if (hold == 0) eep_req = 1'b0;
        else hold--;
      end
    end
    chk("rnd_final_idle", 32'(idle), 32'd1);
    chk("rnd_final_pend", 32'(pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/afe_pot_sched.md
Name: afe_pot_sched

Overview:
- Schedules all writes to the analog front-end digital pots (CH1, CH2, CH3 gain pots and the trigger-level pot) over the single shared SPI master.
- Shares that SPI master with the calibration-EEPROM access path.
- The command processor posts gain/trigger requests here and gets an immediate ack/err. This block then:
  - coalesces pending requests per target,
  - converts 3-bit gain codes to pot wiper bytes,
  - round-robins the transactions onto SPI with the correct slave enabled.

Parameters:
GAP_CYC, 4, idle clocks enforced after every SPI transaction or EEPROM grant before the next one (1..255)
REFRESH_CYC, 1048576, clocks between automatic refresh sweeps (used only with AFE_REFRESH_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
gain_wrt  in  1  one-cycle pulse: gain request
gain_ch  in  2  target channel 00=CH1 01=CH2 10=CH3 (11 illegal)
gain_code  in  3  analog gain code
trig_wrt  in  1  one-cycle pulse: trigger-level request
trig_lvl  in  8  trigger pot value, legal 46..201
req_ack  out  1  pulse: request(s) accepted
req_err  out  1  pulse: request(s) rejected
eep_req  in  1  level: EEPROM path wants SPI
eep_gnt  out  1  level: EEPROM path owns SPI
spi_wrt  out  1  pulse: start SPI transaction
spi_cmd  out  16  SPI word
spi_done  in  1  pulse: SPI transaction complete
ss_en  out  4  one-hot slave enable {TRIG,CH3,CH2,CH1}
pend  out  4  pending flags {TRIG,CH3,CH2,CH1}
idle  out  1  high when state IDLE and pend==0 and eep_gnt==0

Behaviour:
- Reset values: every output is 0 except idle=1. Pending flags, shadow bytes and the round-robin pointer are cleared; the pointer is set to "last=TRIG", so CH1 is checked first.
- Gain table (code -> wiper byte): 000->02, 001->05, 010->09, 011->14, 100->28, 101->46, 110->6B, 111->DD.
- SPI word is always {8'h13, wiper byte}.
- Request acceptance:
  - On the gain_wrt/trig_wrt edge, the shadow byte is written and the pend bit is set. req_ack pulses the following cycle.
  - A new request to a target that is already pending overwrites its shadow; only the last value is sent.
  - A request to the target currently in flight re-sets its pend bit, so the target is written again later.
  - gain_ch==11, or trig_lvl outside 46..201, gives no state change and a req_err pulse the following cycle.
  - Simultaneous gain_wrt and trig_wrt are processed independently. If either is rejected, req_err pulses; req_ack pulses only if at least one is accepted. Both may pulse in the same cycle.
- FSM states: IDLE, LAUNCH, WAIT, GAP, EEP.
  - IDLE: choose between the EEPROM path and the pots as follows.
    - If eep_req is high and (pend==0 or the last grant went to pots), go to EEP.
    - Otherwise, if pend!=0, pick the first pending target after the last-served one (round robin). Latch spi_cmd, set ss_en one-hot, clear that pend bit, and go to LAUNCH.
  - LAUNCH: spi_wrt=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold ss_en and spi_cmd stable. On spi_done, drop ss_en and go to GAP.
  - GAP: count GAP_CYC clocks with ss_en=0, then go to IDLE.
  - EEP: eep_gnt=1 and ss_en=0 while eep_req stays high. When eep_req falls, eep_gnt drops the same edge and the FSM goes to GAP.
- Pot writes and EEPROM grants alternate when both are waiting, so neither side starves.
- spi_done outside WAIT is ignored.
- Latency: from an accepted request in IDLE with no contention, spi_wrt rises on the 3rd clock after the request edge.
- Asynchronous reset mid-transaction:
  - ss_en, spi_wrt and eep_gnt deassert immediately.
  - All pending work and shadows are lost.

Optional Feature:
- AFE_REFRESH_EN defined:
  - A free-running counter runs while at least one target has ever been written.
  - Every REFRESH_CYC clocks it sets pend for every target written since reset, re-sending the stored shadow values. This guards against pot glitches.
  - A refresh coinciding with a user request to the same target does not corrupt the shadow; the user value wins.
- AFE_REFRESH_EN undefined: no counter logic is built, REFRESH_CYC is unused, and pots are written only on request.

Test Plan:
- Reset, then gain_wrt ch=00 code=000 -> req_ack; spi_wrt with spi_cmd=16'h1302 and ss_en=0001; after spi_done, GAP_CYC clocks, then idle=1.
- Back-to-back gain ch=01 code=100, ch=10 code=111, trig_lvl=8'h80, all posted while busy -> sent round robin as 16'h1328 (ss_en 0010), 16'h13DD (0100), 16'h1380 (1000), each separated by ≥GAP_CYC idle clocks.
- ch=00 code=001 posted twice (code 101 second) before service -> exactly one transaction, 16'h1346.
- gain_ch=11 or trig_lvl=45 or 202 -> req_err, pend unchanged, no SPI activity; trig_lvl=46 and 201 -> req_ack.
- eep_req held while three pot requests are pending -> grants interleave pot/EEP/pot/EEP; ss_en=0 whenever eep_gnt=1.
- Assert rst_n low during WAIT -> ss_en=0 and pend=0 immediately; after release, a stale spi_done is ignored and idle=1.
